pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_pkg.sv | 15 +
 rtl/pc_sequencer_if.sv | 36 +++
 rtl/pc_sequencer_return_stack.sv | 44 ++++
 rtl/pc_sequencer.sv | 139 +++++++++++++
 tb/tb_pc_sequencer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared constants and state encoding for the PC sequencer.
// The return-address stack is a build option enabled by defining PC_RAS_EN.
package pc_pkg;

    localparam int          PC_WIDTH        = 16;
    localparam logic [15:0] PC_RESET_VECTOR = 16'h0000;

    typedef logic [1:0] pc_state_t;

    localparam pc_state_t ST_LOAD    = 2'd0;
    localparam pc_state_t ST_FETCH   = 2'd1;
    localparam pc_state_t ST_STALLED = 2'd2;
    localparam pc_state_t ST_HALTED  = 2'd3;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch/PC-register handshake plus control requests between the core and the PC sequencer.
// master = core side driving requests, slave = the sequencer.
interface pc_sequencer_if
    import pc_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH
);

    logic [WIDTH-1:0] pc;
    logic             mem_ack;
    logic             stall;
    logic             branch_taken;
    logic [WIDTH-1:0] branch_offset;
    logic             jump;
    logic [WIDTH-1:0] jump_target;
    logic             call;
    logic             ret;
    logic             halt;
    logic             mem_req;
    logic [WIDTH-1:0] pc_next;
    logic             pc_write;
    logic             ras_error;

    modport master (
        output pc, mem_ack, stall, branch_taken, branch_offset,
               jump, jump_target, call, ret, halt,
        input  mem_req, pc_next, pc_write, ras_error
    );

    modport slave (
        input  pc, mem_ack, stall, branch_taken, branch_offset,
               jump, jump_target, call, ret, halt,
        output mem_req, pc_next, pc_write, ras_error
    );

endinterface

// File: rtl/pc_sequencer_return_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// a pop when empty is ignored.
module return_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;
    logic [PW:0]      count;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    // ptr always names the next free slot, so the top sits one below it.
    assign top   = mem[ptr - PW'(1)];

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            mem[ptr] <= push_data;
            ptr      <= ptr + PW'(1);
            if (!full)
                count <= count + (PW + 1)'(1);
        end else if (pop && !empty) begin
            ptr   <= ptr - PW'(1);
            count <= count - (PW + 1)'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: drives fetch requests and PC register updates, with stall/halt handling.
// Define PC_RAS_EN to build in the return-address stack for call/ret.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_LOAD    | write RESET_VECTOR into the PC register, no fetch
// ST_FETCH   | request fetch at pc; on ack advance, stall or halt
// ST_STALLED | fetch accepted but held; refetch same pc once stall drops
// ST_HALTED  | idle until reset
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int               WIDTH        = PC_WIDTH,
    parameter int               RAS_DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR)
) (
    input  logic          clock,
    input  logic          reset,
    pc_sequencer_if.slave bus
);

    pc_state_t        state, state_d;
    logic             mem_req, pc_write, advance;
    logic [WIDTH-1:0] pc_inc, redirect;

`ifdef PC_RAS_EN
    logic             push_req, pop_req, ras_err_set;
    logic             stk_full, stk_empty, ras_error;
    logic [WIDTH-1:0] stk_top;
`endif

    always_comb begin
        state_d  = state;
        mem_req  = 1'b0;
        pc_write = 1'b0;
        case (state)
            ST_LOAD: begin
                pc_write = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (bus.mem_ack) begin
                    if (bus.halt)
                        state_d = ST_HALTED;
                    else if (bus.stall)
                        state_d = ST_STALLED;
                    else
                        pc_write = 1'b1;
                end
            end
            ST_STALLED: begin
                if (!bus.stall)
                    state_d = ST_FETCH;
            end
            default: ;
        endcase
        // Reset abandons whatever the current cycle was doing.
        if (reset) begin
            mem_req  = 1'b0;
            pc_write = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            state <= ST_LOAD;
        else
            state <= state_d;
    end

    assign advance = pc_write && (state == ST_FETCH);
    assign pc_inc  = bus.pc + WIDTH'(1);

    always_comb begin
        redirect = pc_inc;
`ifdef PC_RAS_EN
        push_req    = 1'b0;
        pop_req     = 1'b0;
        ras_err_set = 1'b0;
        if (bus.ret) begin
            pop_req     = 1'b1;
            ras_err_set = stk_empty | bus.call;
            redirect    = stk_empty ? pc_inc : stk_top;
        end else if (bus.call) begin
            push_req    = 1'b1;
            ras_err_set = stk_full;
            redirect    = bus.jump_target;
        end else
`else
        if (bus.call)
            redirect = bus.jump_target;
        else
`endif
        if (bus.jump)
            redirect = bus.jump_target;
        else if (bus.branch_taken)
            redirect = pc_inc + bus.branch_offset;
        else
            redirect = pc_inc;
    end

    assign bus.mem_req  = mem_req;
    assign bus.pc_write = pc_write;
    assign bus.pc_next  = (reset || state == ST_LOAD) ? RESET_VECTOR :
                          (advance ? redirect : bus.pc);

`ifdef PC_RAS_EN
    return_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset     (reset),
        .push      (advance & push_req),
        .pop       (advance & pop_req),
        .push_data (pc_inc),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_ff @(posedge clock) begin
        if (reset)
            ras_error <= 1'b0;
        else if (advance && ras_err_set)
            ras_error <= 1'b1;
    end

    assign bus.ras_error = ras_error;
`else
    // Without the stack, ret is deliberately ignored and the depth is unused.
    logic unused_ret;
    localparam int unused_ras_depth = RAS_DEPTH;
    assign unused_ret    = bus.ret;
    assign bus.ras_error = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations, then random traffic,
// all outputs checked each cycle against a queue-based behavioural model.
module tb_pc_sequencer;
    import pc_pkg::*;

    localparam int W = 16;
    localparam int D = 4;
`ifdef PC_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    pc_sequencer_if #(.WIDTH(W)) bus();

    pc_sequencer #(
        .WIDTH        (W),
        .RAS_DEPTH    (D),
        .RESET_VECTOR (16'h0000)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Downstream PC register
    logic [W-1:0] pc_reg = '0;
    assign bus.pc = pc_reg;
    always @(posedge clock) if (bus.pc_write === 1'b1) pc_reg <= bus.pc_next;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit           m_load = 1, m_halt = 0, m_stall = 0, m_err = 0;
    logic [W-1:0] stk[$];
    bit           n_load = 1, n_halt = 0, n_stall = 0, n_err = 0;
    int           n_op = 0;            // 0 none, 1 clear, 2 push, 3 pop
    logic [W-1:0] n_val = '0;

    always @(negedge clock) begin : model_cmp
        bit           e_req, e_wr, chosen;
        logic [W-1:0] e_next, inc;
        n_load = m_load; n_halt = m_halt; n_stall = m_stall; n_err = m_err;
        n_op = 0; e_req = 0; e_wr = 0; e_next = 16'h0000;
        inc = bus.pc + 16'd1;
        if (reset) begin
            n_load = 1; n_halt = 0; n_stall = 0; n_err = 0; n_op = 1;
        end else if (m_load) begin
            e_wr = 1; n_load = 0;
        end else if (m_halt) begin
            e_req = 0;
        end else if (m_stall) begin
            if (!bus.stall) n_stall = 0;
        end else begin
            e_req = 1;
            if (bus.mem_ack) begin
                if (bus.halt) n_halt = 1;
                else if (bus.stall) n_stall = 1;
                else begin
                    e_wr = 1;
                    chosen = 0;
                    if (RAS && bus.ret) begin
                        chosen = 1;
                        if (bus.call) n_err = 1;
                        if (stk.size() == 0) begin
                            e_next = inc; n_err = 1;
                        end else begin
                            e_next = stk[$]; n_op = 3;
                        end
                    end else if (bus.call) begin
                        chosen = 1;
                        e_next = bus.jump_target;
                        if (RAS) begin
                            n_op = 2; n_val = inc;
                            if (stk.size() == D) n_err = 1;
                        end
                    end
                    if (!chosen) begin
                        if (bus.jump) e_next = bus.jump_target;
                        else if (bus.branch_taken) e_next = inc + bus.branch_offset;
                        else e_next = inc;
                    end
                end
            end
        end
        chk("mem_req", bus.mem_req, e_req);
        chk("pc_write", bus.pc_write, e_wr);
        if (e_wr || reset) chk("pc_next", bus.pc_next, e_next);
        chk("ras_error", bus.ras_error, m_err);
    end

    always @(posedge clock) begin
        m_load = n_load; m_halt = n_halt; m_stall = n_stall; m_err = n_err;
        case (n_op)
            1: stk.delete();
            2: begin
                stk.push_back(n_val);
                if (stk.size() > D) void'(stk.pop_front());
            end
            3: void'(stk.pop_back());
            default: ;
        endcase
        n_op = 0;
    end

    // ---------------- stimulus ----------------
    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    task automatic clr();
        bus.mem_ack = 1'b1; bus.stall = 1'b0; bus.halt = 1'b0;
        bus.branch_taken = 1'b0; bus.branch_offset = '0;
        bus.jump = 1'b0; bus.jump_target = '0;
        bus.call = 1'b0; bus.ret = 1'b0;
    endtask

    task automatic do_reset();
        nxt(); reset = 1'b1; clr();
        nxt(); reset = 1'b0;
    endtask

    task automatic go(input logic [W-1:0] tgt);
        nxt(); clr(); bus.jump = 1'b1; bus.jump_target = tgt;
        smp();
    endtask

    logic [W-1:0] ras_list [4];

    initial begin
        ras_list[0] = 16'h0231; ras_list[1] = 16'h0221;
        ras_list[2] = 16'h0211; ras_list[3] = 16'h0201;
        clr();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        smp();
        chk("rst_req", bus.mem_req, 1'b0);
        chk("rst_wr", bus.pc_write, 1'b0);
        chk("rst_next", bus.pc_next, 16'h0000);
        nxt(); reset = 1'b0;
        smp();
        chk("load_wr", bus.pc_write, 1'b1);
        chk("load_next", bus.pc_next, 16'h0000);
        chk("load_req", bus.mem_req, 1'b0);
        nxt(); smp(); chk("seq1", bus.pc_next, 16'h0001);
        nxt(); smp(); chk("seq2", bus.pc_next, 16'h0002);

        // Branch and jump priority
        go(16'h0010);
        nxt(); clr(); bus.branch_taken = 1'b1; bus.branch_offset = 16'hFFFC;
        smp(); chk("branch_neg", bus.pc_next, 16'h000D);
        nxt(); bus.jump = 1'b1; bus.jump_target = 16'h0400;
        smp(); chk("jump_over_br", bus.pc_next, 16'h0400);

        // Call / return / empty return
        go(16'h0020);
        nxt(); clr(); bus.call = 1'b1; bus.jump_target = 16'h0100;
        smp(); chk("call_tgt", bus.pc_next, 16'h0100);
        nxt(); clr(); bus.ret = 1'b1;
        smp(); chk("ret_pc", bus.pc_next, RAS ? 16'h0021 : 16'h0101);
        nxt();
        smp(); chk("ret_empty", bus.pc_next, RAS ? 16'h0022 : 16'h0102);
        nxt(); clr();
        smp(); chk("err_empty", bus.ras_error, RAS);

        // Five nested calls into a four-deep stack
        do_reset();
        for (int i = 0; i < 5; i++) begin
            nxt(); clr(); bus.call = 1'b1; bus.jump_target = 16'h0200 + 16'(i * 16);
        end
        for (int i = 0; i < 4; i++) begin
            nxt(); clr(); bus.ret = 1'b1;
            smp();
            chk("nest_ret", bus.pc_next, RAS ? ras_list[i] : 16'h0241 + 16'(i));
        end
        chk("err_ovf", bus.ras_error, RAS);

        // Stall at 0030
        go(16'h0030);
        nxt(); clr(); bus.stall = 1'b1;
        smp(); chk("stall_wr0", bus.pc_write, 1'b0);
        for (int i = 0; i < 2; i++) begin
            nxt(); smp();
            chk("stall_req", bus.mem_req, 1'b0);
            chk("stall_wr", bus.pc_write, 1'b0);
        end
        nxt(); bus.stall = 1'b0;
        smp(); chk("release_wr", bus.pc_write, 1'b0);
        nxt(); smp();
        chk("refetch_req", bus.mem_req, 1'b1);
        chk("refetch_next", bus.pc_next, 16'h0031);

        // Wrap-around
        go(16'hFFFF);
        nxt(); clr(); smp(); chk("wrap", bus.pc_next, 16'h0000);

        // Halt then reset
        nxt(); clr(); bus.halt = 1'b1;
        smp(); chk("halt_wr", bus.pc_write, 1'b0);
        nxt(); clr();
        for (int i = 0; i < 10; i++) begin
            smp(); chk("halted_req", bus.mem_req, 1'b0);
            nxt();
        end
        reset = 1'b1;
        nxt(); reset = 1'b0;
        smp();
        chk("relaunch_wr", bus.pc_write, 1'b1);
        chk("relaunch_next", bus.pc_next, 16'h0000);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            nxt();
            reset            = ($urandom_range(0, 39) == 0);
            bus.mem_ack      = ($urandom_range(0, 3) != 0);
            bus.stall        = ($urandom_range(0, 7) == 0);
            bus.halt         = ($urandom_range(0, 63) == 0);
            bus.branch_taken = ($urandom_range(0, 3) == 0);
            bus.branch_offset = 16'($urandom);
            bus.jump         = ($urandom_range(0, 7) == 0);
            bus.jump_target  = 16'($urandom);
            bus.call         = ($urandom_range(0, 5) == 0);
            bus.ret          = ($urandom_range(0, 5) == 0);
        end
        nxt(); clr(); reset = 1'b0;
        smp();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
